mmcm_reconfig_seq: RTL and testbench

Runtime video-mode clock sequencer: reprograms an MMCME2 through its Dynamic Reconfiguration Port (DRP) so the pixel clock can switch between parametrised modes, e.g. 25.2 MHz 480p and 74.25 MHz 720p, without a bitstream change. It sits beside the MMCM in the clock-generation layer and runs on the board-oscillator clock. It owns the MMCM reset and publishes a synchronised lock flag for downstream video timing logic. Per mode it performs read-modify-write of a table of DRP registers, then waits for re-lock.

---
 rtl/mmcm_reconfig_seq.sv | 192 +++++++++++++++++++
 tb/tb_mmcm_reconfig_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_reconfig_seq.sv
// mmcm_reconfig_seq: switches the MMCME2 pixel clock between video modes by
// read-modify-writing a per-mode table of DRP registers, then waiting for re-lock.
// Optional watchdog on every DRP wait and the lock wait: define MMCM_RECONF_TIMEOUT_EN.
module mmcm_reconfig_seq #(
   parameter int unsigned NUM_MODES     = 2,
   parameter int unsigned REGS_PER_MODE = 8,
   parameter logic [NUM_MODES*REGS_PER_MODE*39-1:0] MODE_TABLE = '0,
   parameter int unsigned TIMEOUT_CYC   = 65535,
   parameter int unsigned MODE_W        = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [MODE_W-1:0] mode_sel,
   input  logic              mode_req,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [MODE_W-1:0] mode_cur,
   output logic              mmcm_rst,
   output logic              drp_den,
   output logic              drp_dwe,
   output logic [6:0]        drp_daddr,
   output logic [15:0]       drp_di,
   input  logic [15:0]       drp_do,
   input  logic              drp_drdy,
   input  logic              mmcm_locked,
   output logic              clk_locked
);

   localparam int unsigned ENTRY_W = 39;
   localparam int unsigned NUM_ENT = NUM_MODES * REGS_PER_MODE;
   localparam int unsigned ENT_AW  = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;
   localparam int unsigned IDX_W   = (REGS_PER_MODE > 1) ? $clog2(REGS_PER_MODE) : 1;

   typedef enum logic [2:0] {
      IDLE, RST_ON, RD, RD_WAIT, WR, WR_WAIT, RST_OFF, LOCK_WAIT
   } state_t;

   state_t             state;
   logic [MODE_W-1:0]  mode_lat;
   logic [IDX_W-1:0]   reg_idx;
   logic [IDX_W-1:0]   idx_nxt;
   logic [ENT_AW-1:0]  k_cur;
   logic [ENT_AW-1:0]  k_nxt;
   logic [ENTRY_W-1:0] tbl [NUM_ENT];
   logic [ENTRY_W-1:0] ent_cur;
   logic [6:0]         addr_nxt;
   logic               lock_s1;
   logic               lock_s2;
   logic               to_hit;

   // Unpack the flat mode table into one entry per (mode, register)
   for (genvar g = 0; g < NUM_ENT; g++) begin : g_tbl
      assign tbl[g] = MODE_TABLE[g*ENTRY_W +: ENTRY_W];
   end

   // Entry for the current register and address of the following one
   always_comb begin
      idx_nxt  = (reg_idx == IDX_W'(REGS_PER_MODE - 1)) ? reg_idx : reg_idx + IDX_W'(1);
      k_cur    = ENT_AW'(32'(mode_lat) * REGS_PER_MODE + 32'(reg_idx));
      k_nxt    = ENT_AW'(32'(mode_lat) * REGS_PER_MODE + 32'(idx_nxt));
      ent_cur  = tbl[k_cur];
      addr_nxt = tbl[k_nxt][38:32];
   end

`ifdef MMCM_RECONF_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_cnt;

   // Watchdog: counts while waiting, restarts on every entry to a wait state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if (state == RD_WAIT || state == WR_WAIT || state == LOCK_WAIT) begin
         to_cnt <= to_cnt + TO_W'(1);
      end else begin
         to_cnt <= '0;
      end
   end

   assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
   assign to_hit = 1'b0;
`endif

   // Two-flop synchroniser for the asynchronous MMCM LOCKED
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_s1 <= 1'b0;
         lock_s2 <= 1'b0;
      end else begin
         lock_s1 <= mmcm_locked;
         lock_s2 <= lock_s1;
      end
   end

   // Downstream lock flag is never trusted while the MMCM is being reprogrammed
   assign clk_locked = lock_s2 & ~busy;

   // Reconfiguration sequencer with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mode_lat  <= '0;
         reg_idx   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         mode_cur  <= '0;
         mmcm_rst  <= 1'b0;
         drp_den   <= 1'b0;
         drp_dwe   <= 1'b0;
         drp_daddr <= '0;
         drp_di    <= '0;
      end else begin
         done    <= 1'b0;
         err     <= 1'b0;
         drp_den <= 1'b0;
         case (state)
            IDLE: begin
               if (mode_req) begin
                  if (32'(mode_sel) < NUM_MODES) begin
                     mode_lat <= mode_sel;
                     reg_idx  <= '0;
                     busy     <= 1'b1;
                     mmcm_rst <= 1'b1;
                     state    <= RST_ON;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            RST_ON: begin
               drp_den   <= 1'b1;
               drp_dwe   <= 1'b0;
               drp_daddr <= ent_cur[38:32];
               state     <= RD;
            end
            RD: state <= RD_WAIT;
            RD_WAIT: begin
               if (drp_drdy) begin
                  drp_den <= 1'b1;
                  drp_dwe <= 1'b1;
                  drp_di  <= (drp_do & ent_cur[31:16]) | (ent_cur[15:0] & ~ent_cur[31:16]);
                  state   <= WR;
               end else if (to_hit) begin
                  err      <= 1'b1;
                  busy     <= 1'b0;
                  mmcm_rst <= 1'b0;
                  state    <= IDLE;
               end
            end
            WR: state <= WR_WAIT;
            WR_WAIT: begin
               if (drp_drdy) begin
                  if (reg_idx == IDX_W'(REGS_PER_MODE - 1)) begin
                     mmcm_rst <= 1'b0;
                     state    <= RST_OFF;
                  end else begin
                     reg_idx   <= idx_nxt;
                     drp_den   <= 1'b1;
                     drp_dwe   <= 1'b0;
                     drp_daddr <= addr_nxt;
                     state     <= RD;
                  end
               end else if (to_hit) begin
                  err      <= 1'b1;
                  busy     <= 1'b0;
                  mmcm_rst <= 1'b0;
                  state    <= IDLE;
               end
            end
            RST_OFF: state <= LOCK_WAIT;
            LOCK_WAIT: begin
               if (lock_s2) begin
                  mode_cur <= mode_lat;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else if (to_hit) begin
                  err      <= 1'b1;
                  busy     <= 1'b0;
                  mmcm_rst <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mmcm_reconfig_seq.sv
// Bench for mmcm_reconfig_seq: DRP register model with fixed ready latency,
// MMCM lock model, and a scoreboard of expected DRP accesses and done/err pulses.
module tb_mmcm_reconfig_seq;

   localparam int unsigned NM  = 2;
   localparam int unsigned RPM = 2;
   localparam int unsigned MW  = 2;
   localparam int unsigned TO  = 100;
   localparam logic [NM*RPM*39-1:0] TBL = {
      {7'h09, 16'hFF00, 16'h0055},   // mode 1 reg 1
      {7'h08, 16'hF000, 16'h0ABC},   // mode 1 reg 0
      {7'h09, 16'hFFFF, 16'h0000},   // mode 0 reg 1
      {7'h08, 16'h0000, 16'h5678}    // mode 0 reg 0
   };

   localparam int K_RD = 0, K_WR = 1, K_DONE = 2, K_ERR = 3;

   typedef struct {
      int          kind;
      logic [6:0]  a;
      logic [15:0] d;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [MW-1:0] mode_sel;
   logic          mode_req;
   logic          busy, done, err, mmcm_rst, drp_den, drp_dwe, clk_locked;
   logic [MW-1:0] mode_cur;
   logic [6:0]    drp_daddr;
   logic [15:0]   drp_di;
   logic [15:0]   drp_do   = 16'h0000;
   logic          drp_drdy = 1'b0;
   logic          mmcm_locked;

   int  checks = 0;
   int  errors = 0;
   int  rd_cnt = 0;
   int  wr_cnt = 0;
   int  lock_mode;
   ev_t sb[$];

   mmcm_reconfig_seq #(
      .NUM_MODES(NM), .REGS_PER_MODE(RPM), .MODE_TABLE(TBL),
      .TIMEOUT_CYC(TO), .MODE_W(MW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mode_sel(mode_sel), .mode_req(mode_req),
      .busy(busy), .done(done), .err(err), .mode_cur(mode_cur),
      .mmcm_rst(mmcm_rst), .drp_den(drp_den), .drp_dwe(drp_dwe),
      .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_do(drp_do),
      .drp_drdy(drp_drdy), .mmcm_locked(mmcm_locked), .clk_locked(clk_locked)
   );

   always #5 clk = ~clk;

   // DRP register model: drdy three cycles after the enable, contents survive rst_n
   logic [15:0] mem [128];
   logic        mem_ok = 1'b0;
   logic        pend   = 1'b0;
   int          dly    = 0;
   always @(posedge clk) begin
      drp_drdy <= 1'b0;
      if (!mem_ok) begin
         mem[8]  <= 16'h1234;
         mem[9]  <= 16'hABCD;
         mem_ok  <= 1'b1;
      end else if (drp_den) begin
         pend <= 1'b1;
         dly  <= 2;
         if (drp_dwe) mem[drp_daddr] <= drp_di;
         else         drp_do <= mem[drp_daddr];
      end else if (pend) begin
         if (dly == 0) begin
            drp_drdy <= 1'b1;
            pend     <= 1'b0;
         end else begin
            dly <= dly - 1;
         end
      end
   end

   // MMCM lock model: drops during RST, returns 6 cycles after release
   logic locked_m = 1'b0;
   int   lk_cnt   = 0;
   always @(posedge clk) begin
      if (mmcm_rst === 1'b1) begin
         lk_cnt   <= 0;
         locked_m <= 1'b0;
      end else if (lk_cnt < 6) begin
         lk_cnt <= lk_cnt + 1;
      end else begin
         locked_m <= 1'b1;
      end
   end
   assign mmcm_locked = (lock_mode == 0) ? 1'b0 : (lock_mode == 1) ? 1'b1 : locked_m;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic push(input int kind, input logic [6:0] a, input logic [15:0] d);
      ev_t e;
      e.kind = kind; e.a = a; e.d = d;
      sb.push_back(e);
   endtask

   task automatic pop_cmp(input int kind, input logic [6:0] a, input logic [15:0] d);
      ev_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event actual kind=%0d a=%h d=%h required none", kind, a, d);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind || e.a != a || (kind == K_WR && e.d != d)) begin
            errors++;
            $display("FAIL event actual kind=%0d a=%h d=%h required kind=%0d a=%h d=%h",
                     kind, a, d, e.kind, e.a, e.d);
         end
      end
   endtask

   // Monitor: every DRP access and done/err pulse must match the next expected event
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (drp_den) begin
            if (drp_dwe) wr_cnt++;
            else         rd_cnt++;
            chk("mmcm_rst_during_drp", 32'(mmcm_rst), 32'd1);
            pop_cmp(drp_dwe ? K_WR : K_RD, drp_daddr, drp_di);
         end
         if (done) begin
            pop_cmp(K_DONE, 7'(mode_cur), 16'h0);
            chk("mmcm_rst_at_done", 32'(mmcm_rst), 32'd0);
            chk("busy_at_done", 32'(busy), 32'd0);
         end
         if (err) begin
            pop_cmp(K_ERR, 7'(mode_cur), 16'h0);
            chk("busy_at_err", 32'(busy), 32'd0);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"},       32'(busy),       32'd0);
      chk({tag, "_done"},       32'(done),       32'd0);
      chk({tag, "_err"},        32'(err),        32'd0);
      chk({tag, "_mode_cur"},   32'(mode_cur),   32'd0);
      chk({tag, "_mmcm_rst"},   32'(mmcm_rst),   32'd0);
      chk({tag, "_drp_den"},    32'(drp_den),    32'd0);
      chk({tag, "_drp_dwe"},    32'(drp_dwe),    32'd0);
      chk({tag, "_drp_daddr"},  32'(drp_daddr),  32'd0);
      chk({tag, "_drp_di"},     32'(drp_di),     32'd0);
      chk({tag, "_clk_locked"}, 32'(clk_locked), 32'd0);
   endtask

   task automatic request(input logic [MW-1:0] m);
      @(posedge clk); #1;
      mode_sel = m;
      mode_req = 1'b1;
      @(posedge clk); #1;
      mode_req = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && busy == 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      chk({nm, "_completes"}, 32'(ok), 32'd1);
   endtask

   task automatic push_seq(input logic [15:0] w0, input logic [15:0] w1);
      push(K_RD, 7'h08, 16'h0);
      push(K_WR, 7'h08, w0);
      push(K_RD, 7'h09, 16'h0);
      push(K_WR, 7'h09, w1);
   endtask

   initial begin
      bit seen;
      int n;
      rst_n     = 1'b0;
      mode_req  = 1'b0;
      mode_sel  = '0;
      lock_mode = 1;

      // Reset with raw lock held high
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("clk_locked_after_1", 32'(clk_locked), 32'd0);
      @(posedge clk); #1;
      chk("clk_locked_after_2", 32'(clk_locked), 32'd1);

      // Mode 1, with a second request pulsed during the first RD_WAIT
      lock_mode = 2;
      repeat (10) @(posedge clk);
      rd_cnt = 0;
      wr_cnt = 0;
      push_seq(16'h1ABC, 16'hAB55);
      push(K_DONE, 7'd1, 16'h0);
      request(2'd1);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (drp_den) begin
            seen = 1'b1;
            break;
         end
      end
      chk("first_read_seen", 32'(seen), 32'd1);
      @(posedge clk); #1;
      mode_sel = 2'd0;
      mode_req = 1'b1;
      @(posedge clk); #1;
      mode_req = 1'b0;
      wait_drain("mode1");
      chk("mode1_reads", 32'(rd_cnt), 32'd2);
      chk("mode1_writes", 32'(wr_cnt), 32'd2);
      chk("mode1_mode_cur", 32'(mode_cur), 32'd1);
      chk("mode1_clk_locked", 32'(clk_locked), 32'd1);

      // Out-of-range request: err only
      push(K_ERR, 7'd1, 16'h0);
      request(2'd3);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy || drp_den) seen = 1'b1;
      end
      chk("bad_mode_no_activity", 32'(seen), 32'd0);
      chk("bad_mode_err_consumed", 32'(sb.size()), 32'd0);
      chk("bad_mode_mode_cur", 32'(mode_cur), 32'd1);

      // rst_n during the first WR_WAIT
      push(K_RD, 7'h08, 16'h0);
      push(K_WR, 7'h08, 16'h5678);
      request(2'd0);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (drp_den && drp_dwe) begin
            seen = 1'b1;
            break;
         end
      end
      chk("first_write_seen", 32'(seen), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1 check_reset_outputs("midreset");
      chk("midreset_events_consumed", 32'(sb.size()), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (10) @(posedge clk);

      // Normal requests after the aborted one
      push_seq(16'h5678, 16'hAB55);
      push(K_DONE, 7'd0, 16'h0);
      request(2'd0);
      wait_drain("mode0_after_reset");
      chk("mode0_mode_cur", 32'(mode_cur), 32'd0);
      push_seq(16'h5ABC, 16'hAB55);
      push(K_DONE, 7'd1, 16'h0);
      request(2'd1);
      wait_drain("mode1_after_reset");
      chk("mode1b_mode_cur", 32'(mode_cur), 32'd1);

`ifdef MMCM_RECONF_TIMEOUT_EN
      // Lock never returns: watchdog fires 100 cycles into LOCK_WAIT
      lock_mode = 0;
      push_seq(16'h5678, 16'hAB55);
      push(K_ERR, 7'd1, 16'h0);
      request(2'd0);
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (!mmcm_rst) begin
            seen = 1'b1;
            break;
         end
      end
      chk("timeout_rst_released", 32'(seen), 32'd1);
      n = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         n++;
         if (err) break;
      end
      chk("timeout_latency", 32'(n), 32'd101);
      chk("timeout_mmcm_rst", 32'(mmcm_rst), 32'd0);
      chk("timeout_mode_cur", 32'(mode_cur), 32'd1);
      wait_drain("timeout");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
